// File: rtl/shift_reg_pkg.sv
// Shared constants for the 4-bit universal shift register and its sequencer:
// mode-select codes, sequencer FSM state encoding and the data width.
package shift_reg_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_FIN   = 2'b11;

  // Direction bit: 1 shifts left, 0 shifts right.
  function automatic logic [1:0] dir_mode(input logic dir);
    return dir ? S_LEFT : S_RIGHT;
  endfunction

endpackage

// File: rtl/shift_len_counter.sv
// Loadable down-counter with an at-one flag; load has priority over decrement
// and the count saturates at zero.
module shift_len_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         at_one_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving S/D/OE of a 4-bit universal shift register.
// Define SHIFT_SEQ_CTRL_IDLE_HIZ_EN to float the register output (OE=1) while idle.
module shift_seq_ctrl
  import shift_reg_pkg::*;
#(
  parameter int LEN_W = 3
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              START,
  input  logic [DATA_W-1:0] CMD_D,
  input  logic              CMD_DIR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  output logic [1:0]        S,
  output logic [DATA_W-1:0] D,
  output logic              OE,
  output logic              BUSY,
  output logic              DONE
);

`ifdef SHIFT_SEQ_CTRL_IDLE_HIZ_EN
  localparam logic IDLE_OE = 1'b1;
`else
  localparam logic IDLE_OE = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              dir_q, dir_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic [1:0]        s_q, s_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              cnt_at_one;

  assign accept = (state_q == ST_IDLE) && START;

  // The counter is loaded during LOAD so it already holds the length on the
  // first SHIFT cycle.
  shift_len_counter #(
    .W(LEN_W)
  ) u_len_cnt (
    .clk        (CLK),
    .rst_n      (CLR_N),
    .load_i     (state_q == ST_LOAD),
    .load_val_i (len_q),
    .dec_i      (state_q == ST_SHIFT),
    .at_one_o   (cnt_at_one)
  );

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    dir_d   = dir_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          dat_d   = CMD_D;
          dir_d   = CMD_DIR;
          len_d   = CMD_LEN;
        end
      end
      ST_LOAD:  state_d = (len_q != '0) ? ST_SHIFT : ST_FIN;
      ST_SHIFT: if (cnt_at_one) state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle as the state they describe.
  always_comb begin
    s_d    = S_HOLD;
    d_d    = '0;
    oe_d   = 1'b0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        oe_d   = IDLE_OE;
        busy_d = 1'b0;
      end
      ST_LOAD: begin
        s_d = S_LOAD;
        d_d = accept ? CMD_D : dat_q;
      end
      ST_SHIFT: s_d = dir_mode(dir_q);
      default:  done_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      dir_q   <= 1'b0;
      len_q   <= '0;
      s_q     <= S_HOLD;
      d_q     <= '0;
      oe_q    <= IDLE_OE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      s_q     <= s_d;
      d_q     <= d_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign D    = d_q;
  assign OE   = oe_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized self-checking bench for shift_seq_ctrl with a cycle-trace model
// and a behavioural downstream shift register.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_CTRL_IDLE_HIZ_EN
  localparam logic IDLE_OE = 1'b1;
`else
  localparam logic IDLE_OE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       START = 1'b0;
  logic [3:0] CMD_D = 4'h0;
  logic       CMD_DIR = 1'b0;
  logic [2:0] CMD_LEN = 3'd0;
  logic [1:0] S;
  logic [3:0] D;
  logic       OE, BUSY, DONE;

  int errors = 0;
  int checks = 0;

  logic [3:0] q_model;

  shift_seq_ctrl #(.LEN_W(3)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .CMD_D(CMD_D),
    .CMD_DIR(CMD_DIR), .CMD_LEN(CMD_LEN), .S(S), .D(D), .OE(OE),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Downstream 4-bit universal shift register, zeros shifted in.
  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) q_model <= 4'h0;
    else case (S)
      2'b11: q_model <= D;
      2'b01: q_model <= {1'b0, q_model[3:1]};
      2'b10: q_model <= {q_model[2:0], 1'b0};
      default: q_model <= q_model;
    endcase
  end

  // Expected {S,D,OE,BUSY,DONE} for cycle idx after START is accepted (idx 0 = load cycle).
  function automatic logic [8:0] exp_out(input logic [3:0] d, input logic dir,
                                         input int len, input int idx);
    if (idx == 0)            return {2'b11, d, 1'b0, 1'b1, 1'b0};
    else if (idx <= len)     return {(dir ? 2'b10 : 2'b01), 4'h0, 1'b0, 1'b1, 1'b0};
    else if (idx == len + 1) return {2'b00, 4'h0, 1'b0, 1'b1, 1'b1};
    else                     return {2'b00, 4'h0, IDLE_OE, 1'b0, 1'b0};
  endfunction

  // Register contents after n shifts of value d.
  function automatic logic [3:0] exp_q(input logic [3:0] d, input logic dir, input int n);
    logic [11:0] t;
    t = {8'h00, d};
    t = dir ? (t << n) : (t >> n);
    return t[3:0];
  endfunction

  function automatic logic [8:0] observed();
    return {S, D, OE, BUSY, DONE};
  endfunction

  task automatic test_reset();
    CLR_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (observed() !== {2'b00, 4'h0, IDLE_OE, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", observed(), {2'b00, 4'h0, IDLE_OE, 2'b00});
    end
    CLR_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (observed() !== {2'b00, 4'h0, IDLE_OE, 2'b00}) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=%h", observed(), {2'b00, 4'h0, IDLE_OE, 2'b00});
    end
    $display("test_reset done");
  endtask

  task automatic test_left_len2();
    logic [8:0] e;
    CMD_D = 4'b1000; CMD_DIR = 1'b1; CMD_LEN = 3'd2; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int idx = 0; idx <= 4; idx++) begin
      if (idx > 0) @(negedge CLK);
      e = exp_out(4'b1000, 1'b1, 2, idx);
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL left_len2_trace idx=%0d got=%h exp=%h", idx, observed(), e);
      end
      if (idx >= 1 && idx <= 3) begin
        checks++;
        if (q_model !== exp_q(4'b1000, 1'b1, idx - 1)) begin
          errors++;
          $display("FAIL left_len2_q idx=%0d got=%b exp=%b", idx, q_model, exp_q(4'b1000, 1'b1, idx - 1));
        end
      end
    end
    $display("test_left_len2 done");
  endtask

  task automatic test_load_only();
    logic [8:0] e;
    CMD_D = 4'b0001; CMD_DIR = 1'b0; CMD_LEN = 3'd0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int idx = 0; idx <= 2; idx++) begin
      if (idx > 0) @(negedge CLK);
      e = exp_out(4'b0001, 1'b0, 0, idx);
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL load_only_trace idx=%0d got=%h exp=%h", idx, observed(), e);
      end
    end
    checks++;
    if (q_model !== 4'b0001) begin
      errors++;
      $display("FAIL load_only_q got=%b exp=0001", q_model);
    end
    $display("test_load_only done");
  endtask

  task automatic test_start_held();
    CMD_D = 4'($urandom); CMD_DIR = 1'($urandom); CMD_LEN = 3'd1; START = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      checks++;
      if (DONE !== ((c % 4) == 3) || BUSY !== ((c % 4) != 0)) begin
        errors++;
        $display("FAIL start_held cycle=%0d got done=%b busy=%b exp done=%b busy=%b",
                 c, DONE, BUSY, (c % 4) == 3, (c % 4) != 0);
      end
      if (c == 10) START = 1'b0;
    end
    $display("test_start_held done");
  endtask

  task automatic test_cmd_change(input int n);
    logic [3:0] d; logic dir; int len; logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      d = 4'($urandom); dir = 1'($urandom); len = $urandom_range(3, 7);
      CMD_D = d; CMD_DIR = dir; CMD_LEN = 3'(len); START = 1'b1;
      for (int idx = 0; idx <= len + 2; idx++) begin
        @(negedge CLK);
        e = exp_out(d, dir, len, idx);
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL cmd_change cmd=%0d idx=%0d got=%h exp=%h", k, idx, observed(), e);
        end
        if (idx < len + 2) begin
          CMD_D = 4'($urandom); CMD_DIR = 1'($urandom);
          CMD_LEN = 3'($urandom); START = 1'($urandom);
        end else begin
          START = 1'b0;
        end
      end
      $display("cmd_change cmd=%0d d=%b dir=%0d len=%0d", k, d, dir, len);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [3:0] d; logic dir; int len; logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      d = 4'($urandom); dir = 1'($urandom); len = $urandom_range(0, 7);
      CMD_D = d; CMD_DIR = dir; CMD_LEN = 3'(len); START = 1'b1;
      for (int idx = 0; idx <= len + 2; idx++) begin
        @(negedge CLK);
        if (idx == 0) START = 1'b0;
        e = exp_out(d, dir, len, idx);
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL b2b_trace cmd=%0d idx=%0d got=%h exp=%h", k, idx, observed(), e);
        end
        if (idx == len + 1) begin
          checks++;
          if (q_model !== exp_q(d, dir, len)) begin
            errors++;
            $display("FAIL b2b_q cmd=%0d got=%b exp=%b", k, q_model, exp_q(d, dir, len));
          end
        end
      end
      $display("b2b cmd=%0d d=%b dir=%0d len=%0d q=%b", k, d, dir, len, q_model);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    CMD_D = 4'b1011; CMD_DIR = 1'b0; CMD_LEN = 3'd5; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    #2 CLR_N = 1'b0;
    #1;
    checks++;
    if (observed() !== {2'b00, 4'h0, IDLE_OE, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", observed(), {2'b00, 4'h0, IDLE_OE, 2'b00});
    end
    @(negedge CLK);
    CLR_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (observed() !== {2'b00, 4'h0, IDLE_OE, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_idle got=%h exp=%h", observed(), {2'b00, 4'h0, IDLE_OE, 2'b00});
    end
    CMD_D = 4'b0110; CMD_DIR = 1'b1; CMD_LEN = 3'd1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    e = exp_out(4'b0110, 1'b1, 1, 0);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL reset_mid_restart got=%h exp=%h", observed(), e);
    end
    repeat (3) @(negedge CLK);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_left_len2();
    test_load_only();
    test_start_held();
    test_cmd_change(6);
    test_back_to_back(20);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
